// File: rtl/min_sad_search_tracker.sv
// Pipelined minimum-SAD search: a registered comparator tree reduces each PE row,
// and an accumulator keeps the running best over one search window.
module min_sad_search_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_COUNT   = 16,
  parameter int ROW_COUNT  = 16,
  localparam int XW = $clog2(PE_COUNT),
  localparam int YW = ($clog2(ROW_COUNT) < 1) ? 1 : $clog2(ROW_COUNT),
  localparam int L  = XW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_start,
  input  logic                           in_valid,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] in_sad_bus,
  output logic                           out_busy,
  output logic                           out_done,
  output logic [DATA_WIDTH-1:0]          out_min_sad,
  output logic [XW-1:0]                  out_mv_x,
  output logic [YW-1:0]                  out_mv_y
);

  localparam int NN = 2 * PE_COUNT;

  if (PE_COUNT < 2 || (PE_COUNT & (PE_COUNT - 1)) != 0) begin : g_bad_pe_count
    $error("PE_COUNT must be a power of two and at least 2");
  end
  if (ROW_COUNT < 1) begin : g_bad_row_count
    $error("ROW_COUNT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN} state_t;

  state_t state;
  logic [YW-1:0] row_cnt;
  logic          accept;

  // Tree laid out as a heap: leaves at PE_COUNT..NN-1 hold the accepted row,
  // node n is the registered winner of children 2n and 2n+1, node 1 is the root.
  logic [DATA_WIDTH-1:0] node_val [1:NN-1];
  logic [XW-1:0]         node_idx [1:NN-1];
  logic [L:0]            vld_p;
  logic [YW-1:0]         tag_p [0:L];

  logic [DATA_WIDTH-1:0] best_val;
  logic [XW-1:0]         best_x;
  logic [YW-1:0]         best_y;

  logic                  root_better;
  logic                  root_last;
  logic [DATA_WIDTH-1:0] nxt_val;
  logic [XW-1:0]         nxt_x;
  logic [YW-1:0]         nxt_y;

  // Right (higher PE index) entry replaces the left only when strictly smaller.
  function automatic logic right_wins(input logic [DATA_WIDTH-1:0] left,
                                      input logic [DATA_WIDTH-1:0] right);
    return right < left;
  endfunction

  assign accept = (state == SEARCH) && in_valid;

  // Stage 0: leaf capture; stages 1..L: one tree level per cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < PE_COUNT; i++) begin
      node_val[PE_COUNT+i] <= in_sad_bus[i*DATA_WIDTH +: DATA_WIDTH];
      node_idx[PE_COUNT+i] <= XW'(i);
    end
    for (int n = 1; n < PE_COUNT; n++) begin
      if (right_wins(node_val[2*n], node_val[2*n+1])) begin
        node_val[n] <= node_val[2*n+1];
        node_idx[n] <= node_idx[2*n+1];
      end else begin
        node_val[n] <= node_val[2*n];
        node_idx[n] <= node_idx[2*n];
      end
    end
    tag_p[0] <= row_cnt;
    for (int k = 1; k <= L; k++) begin
      tag_p[k] <= tag_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[L-1:0], accept};
    end
  end

  // Accumulator: strict compare keeps the earliest row on ties
  always_comb begin
    root_better = vld_p[L] && (node_val[1] < best_val);
    root_last   = vld_p[L] && (tag_p[L] == YW'(ROW_COUNT - 1));
    nxt_val     = best_val;
    nxt_x       = best_x;
    nxt_y       = best_y;
    if (root_better) begin
      nxt_val = node_val[1];
      nxt_x   = node_idx[1];
      nxt_y   = tag_p[L];
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_start) begin
      best_val <= '1;
      best_x   <= '0;
      best_y   <= '0;
    end else begin
      best_val <= nxt_val;
      best_x   <= nxt_x;
      best_y   <= nxt_y;
    end
  end

  // Window control and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row_cnt     <= '0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
      out_min_sad <= '0;
      out_mv_x    <= '0;
      out_mv_y    <= '0;
    end else begin
      out_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_start) begin
            state    <= SEARCH;
            row_cnt  <= '0;
            out_busy <= 1'b1;
          end
        end
        SEARCH: begin
          if (in_valid) begin
            row_cnt <= row_cnt + YW'(1);
            if (row_cnt == YW'(ROW_COUNT - 1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The last row's root result carries the final compare straight into the outputs.
          if (root_last) begin
            out_min_sad <= nxt_val;
            out_mv_x    <= nxt_x;
            out_mv_y    <= nxt_y;
            out_done    <= 1'b1;
            out_busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
